uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers, for example the ALU result path and the debug/echo path.
- Per requester: accepts a byte through a req/ack handshake.
- Toward the transmitter: issues one start pulse with the latched byte, then waits for the transmitter's done pulse before acknowledging the requester.
- Placement: sits between the producers and the UART transmitter's i_tx_signal, i_data_byte and o_done_bit.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
PTR_W, $clog2(NUM_REQ), width of the round-robin pointer and grant index; derived, never overridden.
TIMEOUT_CYCLES, 2000000, watchdog limit in clocks. Used only when TX_TIMEOUT_EN is defined.

Ports:
i_clock  in  1  system clock; all logic on posedge.
i_reset  in  1  synchronous, active-low reset.
i_req  in  NUM_REQ  request per requester; bit k belongs to requester k.
i_data  in  8*NUM_REQ  flat byte bus; requester k drives [8k+7:8k].
o_ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
o_grant  out  NUM_REQ  one-hot grant; all zero when idle.
o_busy  out  1  high whenever the state is not IDLE.
o_tx_start  out  1  one-cycle start pulse; connects to the transmitter's i_tx_signal.
o_tx_byte  out  8  latched byte; connects to the transmitter's i_data_byte.
i_tx_done  in  1  done pulse; connects to the transmitter's o_done_bit.
o_timeout  out  1  one-cycle watchdog-expiry flag; constant 0 when the feature is compiled out.

Behaviour:
- Output timing: every output decodes from registered state only. There is no combinational path from any input to any output.
- Reset (i_reset=0 at a clock edge):
  - State goes to IDLE.
  - rr_ptr=0, sel=0, o_tx_byte=8'h00, watchdog counter=0.
  - o_ack, o_grant, o_busy, o_tx_start and o_timeout are all 0.
  - Reset mid-transfer aborts silently: no ack is issued. The transmitter is reset from the same net.
- States: IDLE -> START -> WAIT -> ACK -> IDLE.
- IDLE:
  - If any i_req bit is set, the winner is the first set bit at index rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - On that edge: sel<=winner, o_tx_byte<=i_data[winner], state<=START.
  - If no bit is set, stay in IDLE.
- START:
  - o_tx_start=1 for exactly this one cycle.
  - o_grant[sel]=1, o_busy=1.
  - Unconditionally go to WAIT.
- WAIT:
  - o_tx_start=0; o_grant and o_busy stay high.
  - Stay in WAIT until i_tx_done=1 is sampled, then go to ACK.
- ACK:
  - o_ack[sel]=1 for one cycle; o_grant is still held.
  - rr_ptr<=(sel+1) mod NUM_REQ, then go to IDLE.
- Latency: request sampled at edge 0 -> o_tx_start high in cycle 1. Done sampled at edge n -> o_ack high in the following cycle.
- Requester rules:
  - Hold i_req and i_data stable until o_ack is seen.
  - Drop i_req on the edge that samples o_ack.
  - A request still high in the first IDLE cycle after ACK counts as a new request. It loses priority to any other pending requester because rr_ptr has advanced.
- Data capture:
  - i_data is sampled only at the IDLE grant edge.
  - Changes to i_data after that edge do not affect o_tx_byte.
- i_tx_done handling: i_tx_done is ignored in IDLE, START and ACK, so spurious pulses have no effect.
- Requests during a transfer:
  - Requests arriving in START, WAIT or ACK are held pending.
  - They are arbitrated at the next IDLE cycle.
- Fairness: with all requests held continuously, service order is rr_ptr, rr_ptr+1, ... Every requester is served within NUM_REQ transfers.

Optional Feature:
TX_TIMEOUT_EN
- Defined:
  - A 32-bit watchdog counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - If the counter reaches TIMEOUT_CYCLES-1 without i_tx_done, go to ACK with o_timeout=1 during the ACK cycle. The requester is still released via o_ack[sel].
  - If i_tx_done and expiry occur in the same cycle, done wins and o_timeout stays 0.
- Not defined:
  - No counter logic is built.
  - o_timeout is tied to 0.
  - WAIT waits indefinitely for i_tx_done.

Test Plan:
- Single request: i_req=4'b0100 with i_data[23:16]=8'hA5, rr_ptr=0.
  -> o_tx_start pulses 1 cycle after req with o_tx_byte=8'hA5 and o_grant=4'b0100.
  -> After i_tx_done, o_ack=4'b0100 for 1 cycle; rr_ptr becomes 3.
- Contention after reset: all four requesters hold req with bytes 8'h10, 8'h11, 8'h12, 8'h13; each drops req on its ack.
  -> o_tx_byte sequence is 10, 11, 12, 13; exactly 4 o_tx_start pulses.
- Priority wrap: set rr_ptr=3 by first serving requester 2, then assert req 0 and req 1 together.
  -> Requester 0 is granted first, then requester 1.
- Reset mid-transfer: drive i_reset=0 for 1 cycle while in WAIT.
  -> Next cycle: o_busy=0, o_grant=0, no o_ack pulse; a new req is granted to requester 0.
- Spurious done: pulse i_tx_done in IDLE and in START.
  -> No o_ack; the transfer still waits for a WAIT-state done.
- With TX_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, request with no i_tx_done.
  -> o_ack and o_timeout are both high in the same cycle, 16 cycles after WAIT entry.
  -> Without the macro, the same stimulus leaves o_busy=1 indefinitely.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Define TX_TIMEOUT_EN to build a WAIT-state watchdog that forces ACK and pulses o_timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [8*NUM_REQ-1:0] i_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_byte,
  input  logic                 i_tx_done,
  output logic                 o_timeout
);
  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_ACK} state_t;

  state_t                    state, state_nxt;
  logic [PTR_W-1:0]          rr_ptr, sel, winner;
  logic [PTR_W:0]            idx;
  logic                      found;
  logic                      expire;
  logic [NUM_REQ-1:0][7:0]   data_bytes;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  assign data_bytes = i_data;

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (idx >= (PTR_W+1)'(NUM_REQ)) idx = idx - (PTR_W+1)'(NUM_REQ);
      if (!found && i_req[idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (found) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (i_tx_done || expire) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!i_reset) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      sel       <= '0;
      o_tx_byte <= 8'h00;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && found) begin
        sel       <= winner;
        o_tx_byte <= data_bytes[winner];
      end
      if (state == S_ACK) begin
        rr_ptr <= (sel == PTR_W'(NUM_REQ-1)) ? '0 : sel + PTR_W'(1);
      end
    end
  end

`ifdef TX_TIMEOUT_EN
  logic [31:0] wd_cnt;
  logic        timeout_q;

  // Done wins over expiry when both land in the same WAIT cycle.
  assign expire = (state == S_WAIT) && !i_tx_done && (wd_cnt == 32'(TIMEOUT_CYCLES-1));

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == S_START)     wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 32'd1;
      timeout_q <= expire;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign expire    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Outputs decode from registered state only.
  assign o_busy     = (state != S_IDLE);
  assign o_tx_start = (state == S_START);
  assign o_grant    = o_busy ? (NUM_REQ'(1) << sel) : '0;
  assign o_ack      = (state == S_ACK) ? (NUM_REQ'(1) << sel) : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-level round-robin model (pending set, pointer, latched byte per transfer).
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           i_clock = 1'b0;
  logic           i_reset;
  logic [N-1:0]   i_req;
  logic [8*N-1:0] i_data;
  logic           i_tx_done;
  logic [N-1:0]   o_ack, o_grant;
  logic           o_busy, o_tx_start, o_timeout;
  logic [7:0]     o_tx_byte;

  int         n_checks  = 0;
  int         n_fail    = 0;
  int         n_starts  = 0;
  int         model_ptr = 0;
  logic [7:0] bytes [N];

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_req     (i_req),
    .i_data    (i_data),
    .o_ack     (o_ack),
    .o_grant   (o_grant),
    .o_busy    (o_busy),
    .o_tx_start(o_tx_start),
    .o_tx_byte (o_tx_byte),
    .i_tx_done (i_tx_done),
    .o_timeout (o_timeout)
  );

  always #5 i_clock = ~i_clock;

  always @(negedge i_clock) if (o_tx_start === 1'b1) n_starts++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    return N'(1) << k;
  endfunction

  function automatic bit is_pending(input int k);
    logic [N-1:0] t;
    t = i_req >> k;
    return t[0];
  endfunction

  // Round-robin rule: first pending requester at model_ptr, model_ptr+1, ... mod N.
  function automatic int model_winner();
    for (int i = 0; i < N; i++)
      if (is_pending((model_ptr + i) % N)) return (model_ptr + i) % N;
    return 0;
  endfunction

  task automatic drive_data();
    for (int k = 0; k < N; k++) i_data[8*k +: 8] = bytes[k];
  endtask

  task automatic add_random_reqs();
    logic [N-1:0] m;
    m = N'($urandom);
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] t;
      t = m >> k;
      if (t[0] && !is_pending(k)) begin
        bytes[k] = 8'($urandom);
        i_req    = i_req | onehot(k);
      end
    end
    drive_data();
  endtask

  // One reset edge; afterwards every output must be at its reset value.
  task automatic reset_pulse();
    i_reset   = 1'b0;
    i_req     = '0;
    i_tx_done = 1'b0;
    @(posedge i_clock); #1;
    i_reset   = 1'b1;
    model_ptr = 0;
    @(negedge i_clock);
    check("rst_busy",    o_busy, 0);
    check("rst_grant",   o_grant, 0);
    check("rst_ack",     o_ack, 0);
    check("rst_start",   o_tx_start, 0);
    check("rst_byte",    o_tx_byte, 0);
    check("rst_timeout", o_timeout, 0);
  endtask

  task automatic idle_cycles(input int n, input bit spur_done);
    for (int i = 0; i < n; i++) begin
      if (spur_done) i_tx_done = 1'b1;
      @(negedge i_clock);
      check("idle_quiet", {o_busy, o_ack, o_tx_start}, 0);
      @(posedge i_clock); #1;
      i_tx_done = 1'b0;
    end
  endtask

  // Called #1 after an edge into an IDLE cycle with at least one request held.
  task automatic run_transfer(input bit spur_start, input int wait_cycles, input bit add_reqs);
    int w;
    logic [7:0] b;
    w = model_winner();
    b = bytes[w];
    @(posedge i_clock); #1;
    if (spur_start) i_tx_done = 1'b1;
    @(negedge i_clock);
    check("start_pulse",  o_tx_start, 1);
    check("start_grant",  o_grant, onehot(w));
    check("start_byte",   o_tx_byte, b);
    check("start_no_ack", o_ack, 0);
    @(posedge i_clock); #1;
    i_tx_done = 1'b0;
    bytes[w]  = 8'($urandom);
    drive_data();
    if (add_reqs) add_random_reqs();
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge i_clock);
      check("wait_state", {o_busy, o_tx_start, o_ack}, {1'b1, 1'b0, 4'b0000});
      @(posedge i_clock); #1;
    end
    i_tx_done = 1'b1;
    @(negedge i_clock);
    check("wait_grant", {o_grant, o_ack}, {onehot(w), 4'b0000});
    @(posedge i_clock); #1;
    i_tx_done = 1'($urandom_range(0, 1));
    @(negedge i_clock);
    check("ack_pulse",      o_ack, onehot(w));
    check("ack_grant",      o_grant, onehot(w));
    check("ack_byte_held",  o_tx_byte, b);
    check("ack_no_timeout", o_timeout, 0);
    @(posedge i_clock); #1;
    i_tx_done = 1'b0;
    i_req     = i_req & ~onehot(w);
    model_ptr = (w + 1) % N;
    @(negedge i_clock);
    check("idle_after_ack", {o_busy, o_grant, o_ack, o_tx_start}, 0);
  endtask

  initial begin
    i_reset   = 1'b0;
    i_req     = '0;
    i_tx_done = 1'b0;
    for (int k = 0; k < N; k++) bytes[k] = 8'h00;
    drive_data();
    reset_pulse();

    // Single request from requester 2, then wrap from pointer 3 to requesters 0 and 1.
    bytes[2] = 8'hA5;
    drive_data();
    i_req = 4'b0100;
    run_transfer(1'b0, 3, 1'b0);
    bytes[0] = 8'h3C;
    bytes[1] = 8'hC3;
    drive_data();
    i_req = 4'b0011;
    run_transfer(1'b0, 1, 1'b0);
    run_transfer(1'b0, 0, 1'b0);

    // Spurious done in IDLE and in START.
    idle_cycles(3, 1'b1);
    bytes[3] = 8'h5A;
    drive_data();
    i_req = 4'b1000;
    run_transfer(1'b1, 2, 1'b0);

    // Contention right after reset: service order 0,1,2,3 and exactly four starts.
    reset_pulse();
    n_starts = 0;
    for (int k = 0; k < N; k++) bytes[k] = 8'h10 + 8'(k);
    drive_data();
    i_req = 4'b1111;
    for (int k = 0; k < N; k++) run_transfer(1'b0, $urandom_range(0, 3), 1'b0);
    idle_cycles(2, 1'b0);
    check("contention_starts", n_starts, 4);

    // Reset during WAIT: silent abort, pointer back to 0.
    bytes[1] = 8'h77;
    drive_data();
    i_req = 4'b0010;
    run_transfer(1'b0, 1, 1'b0);
    i_req = 4'b0100;
    @(posedge i_clock); #1;
    @(posedge i_clock); #1;
    @(negedge i_clock);
    check("pre_reset_busy", o_busy, 1);
    reset_pulse();
    idle_cycles(2, 1'b0);
    bytes[0] = 8'h01;
    bytes[3] = 8'h08;
    drive_data();
    i_req = 4'b1001;
    run_transfer(1'b0, 1, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      if (i_req == '0) begin
        idle_cycles($urandom_range(0, 3), 1'($urandom_range(0, 1)));
        while (i_req == '0) add_random_reqs();
      end
      run_transfer(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < N; k++)
      if (i_req != '0) run_transfer(1'b0, 0, 1'b0);

    // Transmitter never answers.
    begin
      int w;
      bytes[2] = 8'hEE;
      drive_data();
      i_req = i_req | 4'b0100;
      w = model_winner();
      @(posedge i_clock); #1;
      @(posedge i_clock); #1;
`ifdef TX_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
        @(negedge i_clock);
        check("wd_waiting", {o_busy, o_ack, o_timeout}, {1'b1, 4'b0000, 1'b0});
        @(posedge i_clock); #1;
      end
      @(negedge i_clock);
      check("wd_ack",     o_ack, onehot(w));
      check("wd_timeout", o_timeout, 1);
      @(posedge i_clock); #1;
      i_req     = i_req & ~onehot(w);
      model_ptr = (w + 1) % N;
      @(negedge i_clock);
      check("wd_idle", {o_busy, o_timeout}, 0);
`else
      for (int i = 0; i < 40; i++) begin
        @(negedge i_clock);
        check("hang_busy", {o_busy, o_grant, o_ack, o_timeout}, {1'b1, onehot(w), 4'b0000, 1'b0});
        @(posedge i_clock); #1;
      end
      reset_pulse();
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
